pwm_multi: RTL and testbench

//   Multi-channel PWM generator with a parametrised width and a shared programmable period and prescaler.

---
 rtl/pwm_multi_if.sv | 28 ++
 rtl/pwm_multi.sv | 120 ++++++++++++
 tb/tb_pwm_multi.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_if.sv
// Bus bundle for pwm_multi: staged configuration, per-channel controls and the timebase outputs.
// The master side drives configuration; the slave (the PWM block) drives the outputs.
interface pwm_multi_if #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned PRESC_WIDTH = 8
);
    logic                      enable;
    logic [PRESC_WIDTH-1:0]    prescale;
    logic [WIDTH-1:0]          period;
    logic                      center_mode;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic                      duty_load;
    logic [CHANNELS-1:0]       polarity;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_start;
    logic [WIDTH-1:0]          count;

    modport master (
        output enable, prescale, period, center_mode, duty, duty_load, polarity,
        input  pwm_out, period_start, count
    );

    modport slave (
        input  enable, prescale, period, center_mode, duty, duty_load, polarity,
        output pwm_out, period_start, count
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared prescaled timebase, edge/centre-aligned counting and
// double-buffered period/mode/duty that only switch at a period boundary.
module pwm_multi #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned PRESC_WIDTH = 8
) (
    input logic        clk_i,
    input logic        reset_i,
    pwm_multi_if.slave bus_io
);
    typedef enum logic {DirUp, DirDown} dir_e;

    logic [PRESC_WIDTH-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    dir_e                      dir_q, dir_d;
    logic [WIDTH-1:0]          act_per_q, act_per_d, shd_per_q, shd_per_d;
    logic                      act_ctr_q, act_ctr_d, shd_ctr_q, shd_ctr_d;
    logic [CHANNELS*WIDTH-1:0] act_duty_q, act_duty_d, shd_duty_q, shd_duty_d;
    logic                      pend_q, pend_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      ps_q, ps_d;
    logic                      tick, boundary;

    always_comb begin
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        act_per_d  = act_per_q;
        act_ctr_d  = act_ctr_q;
        act_duty_d = act_duty_q;
        shd_per_d  = shd_per_q;
        shd_ctr_d  = shd_ctr_q;
        shd_duty_d = shd_duty_q;
        pend_d     = pend_q;
        pwm_d      = bus_io.polarity;
        ps_d       = 1'b0;
        tick       = 1'b0;
        boundary   = 1'b0;

        if (!bus_io.enable) begin
            // Idle: every cycle is a boundary so pending values land immediately.
            presc_d  = '0;
            cnt_d    = '0;
            dir_d    = DirUp;
            boundary = 1'b1;
        end else begin
            tick    = (presc_q >= bus_io.prescale);
            presc_d = tick ? '0 : presc_q + 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_d[i] = (cnt_q < act_duty_q[i*WIDTH +: WIDTH]) ^ bus_io.polarity[i];
            end
            if (tick) begin
                if (!act_ctr_q) begin
                    boundary = (cnt_q == act_per_q);
                    cnt_d    = boundary ? '0 : cnt_q + 1'b1;
                end else begin
                    boundary = (act_per_q == '0) || (dir_q == DirDown && cnt_q == WIDTH'(1));
                    if (act_per_q == '0)    cnt_d = '0;
                    else if (dir_q == DirUp) cnt_d = cnt_q + 1'b1;
                    else                     cnt_d = cnt_q - 1'b1;
                    if (cnt_d == act_per_q && act_per_q != '0) dir_d = DirDown;
                    else if (cnt_d == '0)                      dir_d = DirUp;
                end
                ps_d = boundary;
            end
        end

        if (boundary && pend_q) begin
            act_per_d  = shd_per_q;
            act_ctr_d  = shd_ctr_q;
            act_duty_d = shd_duty_q;
            pend_d     = 1'b0;
            cnt_d      = '0;
            dir_d      = DirUp;
        end

        // A load on a boundary tick is captured here but waits for the next boundary.
        if (bus_io.duty_load) begin
            shd_per_d  = bus_io.period;
            shd_ctr_d  = bus_io.center_mode;
            shd_duty_d = bus_io.duty;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            dir_q      <= DirUp;
            act_per_q  <= '1;
            act_ctr_q  <= 1'b0;
            act_duty_q <= '0;
            shd_per_q  <= '1;
            shd_ctr_q  <= 1'b0;
            shd_duty_q <= '0;
            pend_q     <= 1'b0;
            pwm_q      <= '0;
            ps_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            act_per_q  <= act_per_d;
            act_ctr_q  <= act_ctr_d;
            act_duty_q <= act_duty_d;
            shd_per_q  <= shd_per_d;
            shd_ctr_q  <= shd_ctr_d;
            shd_duty_q <= shd_duty_d;
            pend_q     <= pend_d;
            pwm_q      <= pwm_d;
            ps_q       <= ps_d;
        end
    end

    assign bus_io.pwm_out      = pwm_q;
    assign bus_io.period_start = ps_q;
    assign bus_io.count        = cnt_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: directed scenarios then random traffic, compared every clock
// against a period-position model of the timebase and shadow registers.
module tb_pwm_multi;
    localparam int W  = 8;
    localparam int CH = 4;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pwm_multi_if #(.WIDTH(W), .CHANNELS(CH), .PRESC_WIDTH(PW)) bus ();

    pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESC_WIDTH(PW)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus_io  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: position k within the current period, cycles since last tick, active/shadow config.
    int          m_k, m_presc;
    int          a_p, s_p;
    bit          a_c, s_c, pend;
    int          a_d[CH], s_d[CH];
    logic [CH-1:0] e_pwm;
    logic        e_ps;

    function automatic int mlen();
        if (a_c) return (a_p == 0) ? 1 : 2 * a_p;
        return a_p + 1;
    endfunction

    function automatic int mcount();
        if (!a_c) return m_k;
        return (m_k <= a_p) ? m_k : 2 * a_p - m_k;
    endfunction

    task automatic model_reset();
        m_k = 0; m_presc = 0; a_p = 255; s_p = 255; a_c = 0; s_c = 0; pend = 0;
        for (int i = 0; i < CH; i++) begin a_d[i] = 0; s_d[i] = 0; end
        e_pwm = '0; e_ps = 1'b0;
    endtask

    task automatic model_step();
        int c;
        bit bnd;
        c = mcount();
        bnd = 0;
        e_ps = 1'b0;
        if (!bus.enable) begin
            e_pwm = bus.polarity; m_presc = 0; m_k = 0; bnd = 1;
        end else begin
            for (int i = 0; i < CH; i++) e_pwm[i] = (c < a_d[i]) ^ bus.polarity[i];
            if (m_presc >= int'(bus.prescale)) begin
                m_presc = 0;
                m_k = (m_k + 1) % mlen();
                if (m_k == 0) begin bnd = 1; e_ps = 1'b1; end
            end else begin
                m_presc++;
            end
        end
        if (bnd && pend) begin
            a_p = s_p; a_c = s_c; a_d = s_d; pend = 0; m_k = 0;
        end
        if (bus.duty_load) begin
            s_p = int'(bus.period); s_c = bus.center_mode; pend = 1;
            for (int i = 0; i < CH; i++) s_d[i] = int'(bus.duty[i*W +: W]);
        end
    endtask

    task automatic check(input string tag);
        logic [W-1:0] ec;
        ec = W'(mcount());
        total++;
        assert (bus.pwm_out === e_pwm) else begin
            bad++; $error("FAIL %s pwm_out obs=%b exp=%b", tag, bus.pwm_out, e_pwm);
        end
        total++;
        assert (bus.period_start === e_ps) else begin
            bad++; $error("FAIL %s period_start obs=%b exp=%b", tag, bus.period_start, e_ps);
        end
        total++;
        assert (bus.count === ec) else begin
            bad++; $error("FAIL %s count obs=%0d exp=%0d", tag, bus.count, ec);
        end
    endtask

    task automatic cyc(input string tag, input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            model_step();
            #1;
            check(tag);
        end
    endtask

    task automatic load(input int p, input bit c, input int d0, input int d1, input int d2,
                        input int d3);
        bus.period = W'(p); bus.center_mode = c;
        bus.duty = {W'(d3), W'(d2), W'(d1), W'(d0)};
        bus.duty_load = 1'b1;
    endtask

    initial begin
        bus.enable = 1'b0; bus.prescale = '0; bus.period = '0; bus.center_mode = 1'b0;
        bus.duty = '0; bus.duty_load = 1'b0; bus.polarity = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        #1 check("reset");
        #10 reset = 1'b0;

        // Edge mode, P=9, duty0=3
        load(9, 0, 3, 0, 0, 0); cyc("t1_load", 1);
        bus.duty_load = 1'b0;   cyc("t1_apply", 1);
        bus.enable = 1'b1;      cyc("t1_edge", 30);

        // Centre mode, P=4, duty0=2
        bus.enable = 1'b0; load(4, 1, 2, 0, 0, 0); cyc("t2_load", 1);
        bus.duty_load = 1'b0; cyc("t2_apply", 1);
        bus.enable = 1'b1;    cyc("t2_centre", 24);

        // P=255, prescale=3, extreme duties, ch3 inverted
        bus.enable = 1'b0; bus.prescale = 8'd3; bus.polarity = 4'b1000;
        load(255, 0, 0, 0, 255, 200); cyc("t3_load", 1);
        bus.duty_load = 1'b0; cyc("t3_apply", 1);
        bus.enable = 1'b1;    cyc("t3_long", 1100);

        // Double-buffered updates: last write wins, boundary strobe defers one period
        bus.enable = 1'b0; bus.prescale = '0; bus.polarity = '0;
        load(9, 0, 5, 0, 0, 0); cyc("t4_load", 1);
        bus.duty_load = 1'b0; cyc("t4_apply", 1);
        bus.enable = 1'b1;    cyc("t4_run", 4);
        load(9, 0, 8, 0, 0, 0); cyc("t4_ld8", 1);
        bus.duty_load = 1'b0; cyc("t4_mid", 2);
        load(9, 0, 2, 0, 0, 0); cyc("t4_ld2", 1);
        bus.duty_load = 1'b0; cyc("t4_after", 25);
        for (int g = 0; g < 20 && m_k != a_p; g++) cyc("t4_seek", 1);
        load(9, 0, 7, 0, 0, 0); cyc("t4_bnd_ld", 1);
        bus.duty_load = 1'b0; cyc("t4_defer", 25);

        // Enable drop with pending load and polarity 0101
        bus.polarity = 4'b0101; cyc("t5_run", 3);
        load(6, 0, 4, 1, 6, 7); cyc("t5_ld", 1);
        bus.duty_load = 1'b0; bus.enable = 1'b0; cyc("t5_off", 4);
        bus.enable = 1'b1; cyc("t5_on", 20);

        // Asynchronous reset mid-period
        @(posedge clk); #3 reset = 1'b1;
        #1;
        model_reset();
        check("t6_async");
        @(posedge clk); #3 reset = 1'b0;
        bus.polarity = '0; bus.duty_load = 1'b0; bus.enable = 1'b1;
        cyc("t6_idle", 20);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            bus.duty_load = 1'b0;
            if ($urandom_range(99) < 4) begin
                int p;
                p = $urandom_range(12);
                load(p, 1'($urandom_range(1)), $urandom_range(p + 2), $urandom_range(p + 2),
                     $urandom_range(p + 2), $urandom_range(p + 2));
            end
            if ($urandom_range(99) < 3) bus.polarity = 4'($urandom_range(15));
            if ($urandom_range(99) < 2) bus.prescale = 8'($urandom_range(3));
            if ($urandom_range(99) < 3) bus.enable = ~bus.enable;
            else if (!bus.enable && $urandom_range(99) < 30) bus.enable = 1'b1;
            cyc("rand", 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
